drum_mem_unit: RTL and testbench
================================

Name: drum_mem_unit

Overview:
- Responder end of the memory-read pulse protocol issued by the pulse distributor. Also serves write requests from arithmetic control.
- Models the magnetic drum: a rotating position counter selects which word slot passes the heads. A request waits until its address comes under the heads, then the access is performed and a one-cycle reply pulse is returned.
- Sits between the pulse distributor, select register, arithmetic control and panel.

Parameters:
- ADDR_W, 10, word address width; the drum holds 2^ADDR_W words.
- DATA_W, 31, word width.
- SECTOR_CYCLES, 4, clocks per word slot; must be >= 1.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- mem_read_from_pu  in  1  pulse, read request
- mem_write_from_ac  in  1  pulse, write request
- addr_from_sel  in  ADDR_W  level, request address; sampled on the request pulse
- wdata_from_ac  in  DATA_W  level, write data; sampled on the write pulse
- clear_from_pnl  in  1  pulse, clears the sticky overrun flag
- mem_read_reply_to_pu  out  1  pulse, read data valid
- mem_write_reply_to_ac  out  1  pulse, write done
- rdata_to_ac  out  DATA_W  level, last read word, held
- busy_to_pnl  out  1  level, request outstanding
- overrun_to_pnl  out  1  level, sticky, a request was dropped
- drum_pos_to_pnl  out  ADDR_W  level, current slot under heads

Behaviour:
- Reset (resetn=0 at posedge):
  - sub-counter=0, drum_pos=0, state=IDLE.
  - rdata=0, both replies=0, busy=0, overrun=0.
  - Storage array is NOT cleared.
  - Reset mid-request aborts it: no reply, no write.
- Rotation:
  - sub-counter counts 0..SECTOR_CYCLES-1 and wraps.
  - slot_tick = (sub-counter == SECTOR_CYCLES-1).
  - drum_pos increments on slot_tick and wraps 2^ADDR_W-1 -> 0.
  - Rotation runs unconditionally.
- States: IDLE, WAIT_RD, WAIT_WR, REPLY_RD, REPLY_WR.
- IDLE:
  - mem_read_from_pu: latch addr_q <= addr_from_sel, go to WAIT_RD.
  - Else mem_write_from_ac: latch addr_q and wdata_q, go to WAIT_WR.
  - Read and write in the same cycle: read wins, write dropped, overrun set.
- WAIT_x: access cycle = slot_tick && drum_pos == addr_q. On that edge:
  - Read: rdata <= mem[addr_q], go to REPLY_RD.
  - Write: mem[addr_q] <= wdata_q, go to REPLY_WR.
- Match in the capture cycle: matching is evaluated only in WAIT_x. A slot passing in the capture cycle is therefore missed and costs a full revolution.
- REPLY_x: corresponding reply pulse = 1 for exactly one cycle, then IDLE. A new request is accepted in the IDLE cycle that follows.
- Latency: reply = access cycle + 1. Worst case = 2^ADDR_W*SECTOR_CYCLES + 1 cycles after capture.
- busy = (state != IDLE).
- Any request pulse while state != IDLE is ignored and sets overrun.
- overrun clears on clear_from_pnl. If clear and a new overrun coincide, set wins.
- rdata_to_ac changes only on a read access.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE=0, WAIT_RD=1, WAIT_WR=2, REPLY_RD=3, REPLY_WR=4).
  - Default ADDR_W/DATA_W word-format constants, shared with the select register and arithmetic control.
- One natural sub-module: drum_rotor (sub-counter, drum_pos, slot_tick).
- The FSM and storage array stay in drum_mem_unit.

Test Plan:
(All cases use ADDR_W=4, SECTOR_CYCLES=2. Cycle 0 is the first cycle after reset release; slot k ticks at cycle 2k+1 + 32n.)
- Read addr 3, pulse at cycle 0, mem[3]=0x1234 preloaded -> access at cycle 7; reply pulse at cycle 8 only; rdata=0x1234 from cycle 8 and held.
- Read addr 0, pulse at cycle 1 (slot 0 ticks in the capture cycle) -> access at cycle 33, reply at cycle 34, busy=1 on cycles 2..34.
- Write 0x7FFF_FFFF to addr 15, then read addr 15 -> write reply one cycle after the slot-15 tick; the read returns 0x7FFF_FFFF.
- Read pulse arriving while busy -> ignored; overrun=1, no extra reply; clear_from_pnl -> overrun=0 next cycle.
- Read and write pulses in the same IDLE cycle -> only the read is serviced, overrun=1, memory unchanged.
- resetn low during WAIT_WR -> no write reply and target word unchanged; drum_pos=0 and busy=0 after reset.

Source files
------------

// File: rtl/drum_mem_unit_pkg.sv
// drum_mem_unit_pkg
//   Shared definitions for the drum memory unit and its neighbours.
//   - WORD_ADDR_W / WORD_DATA_W: default word-format widths. The select
//     register and arithmetic control use the same values.
//   - mem_state_t: responder FSM encoding. The numeric values are fixed
//     because the panel decodes them.
package drum_mem_unit_pkg;

  localparam int WORD_ADDR_W = 10;
  localparam int WORD_DATA_W = 31;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RD  = 3'd1,
    WAIT_WR  = 3'd2,
    REPLY_RD = 3'd3,
    REPLY_WR = 3'd4
  } mem_state_t;

endpackage

// File: rtl/drum_rotor.sv
// drum_rotor
//   Free-running drum position model. A sub-counter divides the clock into
//   word slots of SECTOR_CYCLES clocks each. The slot position advances at
//   the end of every slot.
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   slot_tick   out   high in the last clock of each slot
//   drum_pos    out   word slot currently under the heads
module drum_rotor
  import drum_mem_unit_pkg::*;
#(
  parameter int ADDR_W        = WORD_ADDR_W,
  parameter int SECTOR_CYCLES = 4
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              slot_tick,
  output logic [ADDR_W-1:0] drum_pos
);

  // Keep the counter at least 1 bit wide so SECTOR_CYCLES=1 still elaborates.
  // With that setting the counter stays at 0 and every clock is a tick.
  localparam int SUB_W = (SECTOR_CYCLES > 1) ? $clog2(SECTOR_CYCLES) : 1;

  logic [SUB_W-1:0] sub_cnt;

  assign slot_tick = (sub_cnt == SUB_W'(SECTOR_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sub_cnt  <= '0;
      drum_pos <= '0;
    end else begin
      if (slot_tick) begin
        sub_cnt  <= '0;
        drum_pos <= drum_pos + ADDR_W'(1);  // wraps naturally at 2^ADDR_W
      end else begin
        sub_cnt  <= sub_cnt + SUB_W'(1);
      end
    end
  end

endmodule

// File: rtl/drum_mem_unit.sv
// drum_mem_unit
//   Drum memory responder. It accepts a read pulse from the pulse distributor
//   or a write pulse from arithmetic control. It then waits until the
//   addressed word slot passes the heads, performs the access, and returns a
//   one-cycle reply pulse.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   mem_read_from_pu       read request pulse
//   mem_write_from_ac      write request pulse
//   addr_from_sel          request address, sampled on the request pulse
//   wdata_from_ac          write data, sampled on the write pulse
//   clear_from_pnl         clears the sticky overrun flag
//   mem_read_reply_to_pu   one-cycle pulse when read data is valid
//   mem_write_reply_to_ac  one-cycle pulse when a write has completed
//   rdata_to_ac            last word read, held until the next read access
//   busy_to_pnl            a request is outstanding
//   overrun_to_pnl         sticky: a request pulse was dropped
//   drum_pos_to_pnl        word slot currently under the heads
module drum_mem_unit
  import drum_mem_unit_pkg::*;
#(
  parameter int ADDR_W        = WORD_ADDR_W,
  parameter int DATA_W        = WORD_DATA_W,
  parameter int SECTOR_CYCLES = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_read_from_pu,
  input  logic              mem_write_from_ac,
  input  logic [ADDR_W-1:0] addr_from_sel,
  input  logic [DATA_W-1:0] wdata_from_ac,
  input  logic              clear_from_pnl,
  output logic              mem_read_reply_to_pu,
  output logic              mem_write_reply_to_ac,
  output logic [DATA_W-1:0] rdata_to_ac,
  output logic              busy_to_pnl,
  output logic              overrun_to_pnl,
  output logic [ADDR_W-1:0] drum_pos_to_pnl
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  mem_state_t        state;
  req_t              req_q;
  logic              slot_tick;
  logic [ADDR_W-1:0] drum_pos;
  logic              access;
  logic              any_req;

  // Drum storage. Reset does not clear it, because the drum keeps its
  // contents through a machine reset.
  logic [DATA_W-1:0] mem [DEPTH];

  drum_rotor #(
    .ADDR_W        (ADDR_W),
    .SECTOR_CYCLES (SECTOR_CYCLES)
  ) u_rotor (
    .clk       (clk),
    .resetn    (resetn),
    .slot_tick (slot_tick),
    .drum_pos  (drum_pos)
  );

  assign drum_pos_to_pnl = drum_pos;
  assign any_req         = mem_read_from_pu | mem_write_from_ac;

  // The access happens in the last clock of the addressed slot. Matching is
  // only evaluated in the WAIT states. A slot that ticks in the capture
  // cycle is therefore missed, and the request waits a full revolution.
  assign access = slot_tick && (drum_pos == req_q.addr);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state                 <= IDLE;
      req_q                 <= '0;
      rdata_to_ac           <= '0;
      mem_read_reply_to_pu  <= 1'b0;
      mem_write_reply_to_ac <= 1'b0;
      busy_to_pnl           <= 1'b0;
      overrun_to_pnl        <= 1'b0;
    end else begin
      mem_read_reply_to_pu  <= 1'b0;
      mem_write_reply_to_ac <= 1'b0;

      // Clear is applied first so that a simultaneous drop sets the flag
      // again (set wins).
      if (clear_from_pnl)
        overrun_to_pnl <= 1'b0;
      if (state != IDLE && any_req)
        overrun_to_pnl <= 1'b1;

      case (state)
        IDLE: begin
          if (mem_read_from_pu) begin
            // A read wins over a concurrent write. The write is dropped.
            req_q.addr  <= addr_from_sel;
            state       <= WAIT_RD;
            busy_to_pnl <= 1'b1;
            if (mem_write_from_ac)
              overrun_to_pnl <= 1'b1;
          end else if (mem_write_from_ac) begin
            req_q.addr  <= addr_from_sel;
            req_q.wdata <= wdata_from_ac;
            state       <= WAIT_WR;
            busy_to_pnl <= 1'b1;
          end
        end
        WAIT_RD: begin
          if (access) begin
            rdata_to_ac          <= mem[req_q.addr];
            mem_read_reply_to_pu <= 1'b1;
            state                <= REPLY_RD;
          end
        end
        WAIT_WR: begin
          if (access) begin
            mem_write_reply_to_ac <= 1'b1;
            state                 <= REPLY_WR;
          end
        end
        REPLY_RD, REPLY_WR: begin
          state       <= IDLE;
          busy_to_pnl <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          busy_to_pnl <= 1'b0;
        end
      endcase
    end
  end

  // The storage write uses the same condition as the WAIT_WR -> REPLY_WR
  // transition. It is gated by resetn so that a reset aborts a pending write.
  always_ff @(posedge clk) begin
    if (resetn && state == WAIT_WR && access)
      mem[req_q.addr] <= req_q.wdata;
  end

endmodule

// File: tb/tb_drum_mem_unit.sv
// tb_drum_mem_unit
//   Directed bench for drum_mem_unit with ADDR_W=4, SECTOR_CYCLES=2.
//   Cycle 0 is the first cycle after reset release. Outputs are sampled on
//   the falling edge. Inputs are driven just after sampling.
module tb_drum_mem_unit;

  localparam int AW = 4;
  localparam int DW = 31;
  localparam int SC = 2;

  logic          clk;
  logic          resetn;
  logic          rd, wr, clr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rrep, wrep, busy, ovr;
  logic [DW-1:0] rdata;
  logic [AW-1:0] pos;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  drum_mem_unit #(.ADDR_W(AW), .DATA_W(DW), .SECTOR_CYCLES(SC)) dut (
    .clk                   (clk),
    .resetn                (resetn),
    .mem_read_from_pu      (rd),
    .mem_write_from_ac     (wr),
    .addr_from_sel         (addr),
    .wdata_from_ac         (wdata),
    .clear_from_pnl        (clr),
    .mem_read_reply_to_pu  (rrep),
    .mem_write_reply_to_ac (wrep),
    .rdata_to_ac           (rdata),
    .busy_to_pnl           (busy),
    .overrun_to_pnl        (ovr),
    .drum_pos_to_pnl       (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic          rrep;
    logic          busy;
    logic [DW-1:0] rdata;
    logic [AW-1:0] pos;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
    cyc++;
    rd  = 1'b0;
    wr  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    rd = 1'b0; wr = 1'b0; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cyc = 0;
  endtask

  task automatic wr_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit seen = 1'b0;
    addr = a; wdata = d; wr = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      next();
      if (wrep) seen = 1'b1;
    end
    chk("write reply seen", 32'(seen), 32'd1);
    next();
  endtask

  task automatic rd_req(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bit seen = 1'b0;
    d = '0;
    addr = a; rd = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      next();
      if (rrep) begin
        seen = 1'b1;
        d = rdata;
      end
    end
    chk("read reply seen", 32'(seen), 32'd1);
    next();
  endtask

  initial begin
    logic [DW-1:0] d;
    addr = '0; wdata = '0;

    // Table for the first read: addr 3, pulse at cycle 0.
    // The position is cycle/2. The slot-3 tick is at cycle 7, so the reply
    // comes at cycle 8.
    tbl[0]  = '{1'b1, 4'd3, 1'b0, 1'b0, 31'h0,    4'd0};
    tbl[1]  = '{1'b0, 4'd0, 1'b0, 1'b1, 31'h0,    4'd0};
    tbl[2]  = '{1'b0, 4'd0, 1'b0, 1'b1, 31'h0,    4'd1};
    tbl[3]  = '{1'b0, 4'd0, 1'b0, 1'b1, 31'h0,    4'd1};
    tbl[4]  = '{1'b0, 4'd0, 1'b0, 1'b1, 31'h0,    4'd2};
    tbl[5]  = '{1'b0, 4'd0, 1'b0, 1'b1, 31'h0,    4'd2};
    tbl[6]  = '{1'b0, 4'd0, 1'b0, 1'b1, 31'h0,    4'd3};
    tbl[7]  = '{1'b0, 4'd0, 1'b0, 1'b1, 31'h0,    4'd3};
    tbl[8]  = '{1'b0, 4'd0, 1'b1, 1'b1, 31'h1234, 4'd4};
    tbl[9]  = '{1'b0, 4'd0, 1'b0, 1'b0, 31'h1234, 4'd4};
    tbl[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 31'h1234, 4'd5};

    // Check the reset state.
    do_reset();
    chk("reset rdata",   32'(rdata), 32'h0);
    chk("reset busy",    32'(busy),  32'h0);
    chk("reset overrun", 32'(ovr),   32'h0);
    chk("reset pos",     32'(pos),   32'h0);
    chk("reset rreply",  32'(rrep),  32'h0);
    chk("reset wreply",  32'(wrep),  32'h0);

    // Preload through the write path. The words must survive the resets
    // that follow.
    wr_req(4'd3, 31'h1234);
    wr_req(4'd0, 31'h0ABC);

    // Read addr 3, pulse at cycle 0 (table driven).
    do_reset();
    for (int i = 0; i < 11; i++) begin
      chk("t1 rreply", 32'(rrep),  32'(tbl[i].rrep));
      chk("t1 busy",   32'(busy),  32'(tbl[i].busy));
      chk("t1 rdata",  32'(rdata), 32'(tbl[i].rdata));
      chk("t1 pos",    32'(pos),   32'(tbl[i].pos));
      rd = tbl[i].rd; addr = tbl[i].addr;
      next();
    end

    // Read addr 0 at cycle 1. Slot 0 ticks in the capture cycle and is
    // missed, so the access is at cycle 33 and the reply at cycle 34.
    do_reset();
    next();
    rd = 1'b1; addr = 4'd0;
    for (int i = 0; i < 39; i++) begin
      next();
      chk("t2 busy",   32'(busy), 32'(cyc >= 2 && cyc <= 34));
      chk("t2 rreply", 32'(rrep), 32'(cyc == 34));
      if (cyc == 35) chk("t2 rdata", 32'(rdata), 32'h0ABC);
    end

    // Write all-ones to addr 15 at cycle 0. Slot 15 ticks at cycle 31, so
    // the reply is at cycle 32. The word is then read back.
    do_reset();
    wr = 1'b1; addr = 4'd15; wdata = 31'h7FFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      next();
      chk("t3 wreply", 32'(wrep), 32'(cyc == 32));
      chk("t3 busy",   32'(busy), 32'(cyc <= 32));
    end
    rd_req(4'd15, d);
    chk("t3 readback", 32'(d), 32'h7FFF_FFFF);

    // Requests while busy are dropped and set overrun. Clear and set at the
    // same time leaves the flag set. A lone clear drops it.
    do_reset();
    rd = 1'b1; addr = 4'd5;
    for (int i = 0; i < 45; i++) begin
      next();
      chk("t4 rreply", 32'(rrep), 32'(cyc == 12));
      if (cyc == 3)  chk("t4 ovr before", 32'(ovr), 32'h0);
      if (cyc == 4)  chk("t4 ovr set",    32'(ovr), 32'h1);
      if (cyc == 6)  chk("t4 set wins",   32'(ovr), 32'h1);
      if (cyc == 20) chk("t4 ovr sticky", 32'(ovr), 32'h1);
      if (cyc == 21) chk("t4 ovr clear",  32'(ovr), 32'h0);
      if (cyc == 3) begin rd = 1'b1; addr = 4'd7; end
      if (cyc == 5) begin rd = 1'b1; clr = 1'b1; end
      if (cyc == 20) clr = 1'b1;
    end

    // Read and write in the same IDLE cycle: the read is served and the
    // write is dropped.
    do_reset();
    rd = 1'b1; wr = 1'b1; addr = 4'd3; wdata = 31'h555;
    for (int i = 0; i < 40; i++) begin
      next();
      chk("t5 wreply", 32'(wrep), 32'h0);
      chk("t5 rreply", 32'(rrep), 32'(cyc == 8));
      if (cyc == 1) chk("t5 ovr",   32'(ovr),   32'h1);
      if (cyc == 9) chk("t5 rdata", 32'(rdata), 32'h1234);
    end
    rd_req(4'd3, d);
    chk("t5 mem unchanged", 32'(d), 32'h1234);

    // Reset during WAIT_WR aborts the write.
    do_reset();
    wr = 1'b1; addr = 4'd3; wdata = 31'h2222;
    for (int i = 0; i < 4; i++) next();
    chk("t6 busy pre", 32'(busy), 32'h1);
    resetn = 1'b0;
    next();
    chk("t6 pos after reset",  32'(pos),  32'h0);
    chk("t6 busy after reset", 32'(busy), 32'h0);
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      next();
      chk("t6 no wreply", 32'(wrep), 32'h0);
    end
    rd_req(4'd3, d);
    chk("t6 word intact", 32'(d), 32'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
